// File: rtl/branch_predictor.sv
// Gshare front-end predictor: 2-bit counter table indexed by speculative history ^ pc,
// with an in-order FIFO of in-flight branches trained and repaired at commit.
module branch_predictor #(
  parameter int PATTERN_WIDTH  = 8,
  parameter int INST_MEM_WIDTH = 14,
  parameter int N_INFLIGHT     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] target,
  output logic                      prediction,
  output logic [PATTERN_WIDTH-1:0]  pattern,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure,
  input  logic                      commit_valid,
  input  logic                      failure,
  output logic                      redirect,
  output logic [INST_MEM_WIDTH-1:0] redirect_addr
);
  localparam int PHT_N = 1 << PATTERN_WIDTH;
  localparam int PTR_W = (N_INFLIGHT > 1) ? $clog2(N_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(N_INFLIGHT + 1);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [PATTERN_WIDTH-1:0]  idx;
    logic                      pred;
    logic [INST_MEM_WIDTH-1:0] aof;
  } entry_t;

  state_t                   state_q, state_d;
  logic [PATTERN_WIDTH-1:0] sweep_q;
  logic [PATTERN_WIDTH-1:0] spec_hist, arch_hist;
  logic [1:0]               pht [PHT_N];
  entry_t                   fifo [N_INFLIGHT];
  logic [PTR_W-1:0]         rd_ptr, wr_ptr;
  logic [CNT_W-1:0]         count;

  logic [PATTERN_WIDTH-1:0] idx;
  entry_t                   head;
  logic                     do_commit, do_issue, fail, actual;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_INFLIGHT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Lookup path: purely combinational from pc/target and registered history/table.
  always_comb begin
    idx             = spec_hist ^ pc[PATTERN_WIDTH-1:0];
    prediction      = (state_q == RUN) && pht[idx][1];
    pattern         = spec_hist;
    addr_on_failure = prediction ? pc + INST_MEM_WIDTH'(1) : target;
    issue_ready     = (state_q == RUN) && ((count < CNT_W'(N_INFLIGHT)) || commit_valid);
    head            = fifo[rd_ptr];
    do_commit       = commit_valid && (count != '0);
    actual          = head.pred ^ failure;
    fail            = do_commit && failure;
    // A branch offered alongside a failing commit is on the wrong path.
    do_issue        = issue_valid && issue_ready && !fail;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_q == '1) state_d = RUN;
      default: ;
    endcase
  end

  // Table is never reset directly; INIT rewrites every entry instead.
  always_ff @(posedge clk) begin
    if (state_q == INIT)
      pht[sweep_q] <= 2'b01;
    else if (do_commit && !reset)
      pht[head.idx] <= sat_upd(pht[head.idx], actual);
  end

  always_ff @(posedge clk) begin
    if (do_issue) fifo[wr_ptr] <= '{idx: idx, pred: prediction, aof: addr_on_failure};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_q       <= '0;
      spec_hist     <= '0;
      arch_hist     <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      redirect      <= 1'b0;
      redirect_addr <= '0;
    end else begin
      redirect <= 1'b0;
      if (state_q == INIT) sweep_q <= sweep_q + PATTERN_WIDTH'(1);
      if (do_issue) begin
        wr_ptr    <= ptr_inc(wr_ptr);
        spec_hist <= {spec_hist[PATTERN_WIDTH-2:0], prediction};
      end
      if (do_commit) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        arch_hist <= {arch_hist[PATTERN_WIDTH-2:0], actual};
      end
      if (fail) begin
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        count         <= '0;
        spec_hist     <= {arch_hist[PATTERN_WIDTH-2:0], actual};
        redirect      <= 1'b1;
        redirect_addr <= head.aof;
      end else if (do_issue && !do_commit) begin
        count <= count + CNT_W'(1);
      end else if (!do_issue && do_commit) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
